// File: rtl/adder_bist_pkg.sv
// Shared types and sizing for the adder_bist self-test controller.
// Optional build macro: ADDER_BIST_STOP_ON_FAIL_EN (see adder_bist.sv).
package adder_bist_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    DONE
  } state_t;

  // One vector is {A, B, C0}; the error counter is one bit wider than the vector.
  function automatic int vec_w(input int width);
    return 2 * width + 1;
  endfunction

  function automatic int cnt_w(input int width);
    return 2 * width + 2;
  endfunction

endpackage

// File: rtl/adder_ref_model.sv
// Combinational golden adder: {cout, sum} = a + b + cin, WIDTH+1 bits wide.
module adder_ref_model #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  assign {cout, sum} = (WIDTH+1)'(a) + (WIDTH+1)'(b) + (WIDTH+1)'(cin);

endmodule

// File: rtl/adder_bist.sv
// Exhaustive BIST sweep for a WIDTH-bit ripple-carry adder: drives every {A,B,C0}
// and checks {C4,F} against a golden sum. Build macro ADDER_BIST_STOP_ON_FAIL_EN
// ends the sweep at the first mismatch instead of running all vectors.
module adder_bist
  import adder_bist_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [WIDTH-1:0]     A,
  output logic [WIDTH-1:0]     B,
  output logic                 C0,
  input  logic [WIDTH-1:0]     F,
  input  logic                 C4,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2*WIDTH+1:0]   err_cnt,
  output logic [2*WIDTH:0]     first_fail
);

  localparam int VW = vec_w(WIDTH);
  localparam int CW = cnt_w(WIDTH);

  state_t          state;
  logic [VW-1:0]   vec;
  logic [WIDTH-1:0] gold_sum;
  logic            gold_cout;
  logic            mismatch;
  logic            stop_now;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  assign A  = vec[2*WIDTH:WIDTH+1];
  assign B  = vec[WIDTH:1];
  assign C0 = vec[0];

  adder_ref_model #(.WIDTH(WIDTH)) u_ref (
    .a    (A),
    .b    (B),
    .cin  (C0),
    .sum  (gold_sum),
    .cout (gold_cout)
  );

  assign mismatch = ({C4, F} != {gold_cout, gold_sum});

`ifdef ADDER_BIST_STOP_ON_FAIL_EN
  assign stop_now = mismatch;
`else
  assign stop_now = 1'b0;
`endif

  // DRIVE lets the adder settle; SAMPLE compares and steps to the next vector.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      vec        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_cnt    <= '0;
      first_fail <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= DRIVE;
            vec        <= '0;
            err_cnt    <= '0;
            first_fail <= '0;
            pass       <= 1'b0;
            busy       <= 1'b1;
          end
        end
        DRIVE: state <= SAMPLE;
        SAMPLE: begin
          if (mismatch) begin
            err_cnt <= sat_inc(err_cnt);
            if (err_cnt == '0)
              first_fail <= vec;
          end
          // pass must account for the compare happening on this same edge
          if ((&vec) || stop_now) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
            pass  <= (err_cnt == '0) && !mismatch;
          end else begin
            vec   <= vec + VW'(1);
            state <= DRIVE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_bist.sv
// Self-checking bench for adder_bist: a behavioural adder with injectable faults,
// and an exhaustive reference count of expected mismatches per sweep.
module tb_adder_bist;

  localparam int W       = 4;
  localparam int NVEC    = 512;
  localparam int FULL_LAT = 1025;
  localparam int MAX_LAT = 3000;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] A, B, F;
  logic         C0, C4;
  logic         busy, done, pass;
  logic [9:0]   err_cnt;
  logic [8:0]   first_fail;

  int checks = 0;
  int errors = 0;

  // 0 = good adder, 1 = F[0] stuck 0, 2 = C4 stuck 0, 3 = random per-vector flips
  int          fault_mode = 0;
  logic [4:0]  flip_tbl [NVEC];

  adder_bist #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .A          (A),
    .B          (B),
    .C0         (C0),
    .F          (F),
    .C4         (C4),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .err_cnt    (err_cnt),
    .first_fail (first_fail)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] adder_out(input int v);
    int a, b, c;
    logic [4:0] r;
    a = (v >> 5) & 15;
    b = (v >> 1) & 15;
    c = v & 1;
    r = 5'(a + b + c);
    case (fault_mode)
      1: r[0] = 1'b0;
      2: r[4] = 1'b0;
      3: r = r ^ flip_tbl[v];
      default: ;
    endcase
    return r;
  endfunction

  always_comb {C4, F} = adder_out(int'({A, B, C0}));

  // Expected results: walk all vectors in sweep order with plain integer sums.
  task automatic model_expect(output int exp_err, output int exp_ff, output int exp_lat);
    int a, b, c;
    exp_err = 0;
    exp_ff  = 0;
    exp_lat = FULL_LAT;
    for (int v = 0; v < NVEC; v++) begin
      a = (v >> 5) & 15;
      b = (v >> 1) & 15;
      c = v & 1;
      if (int'(adder_out(v)) != a + b + c) begin
        if (exp_err == 0) exp_ff = v;
        exp_err++;
      end
    end
`ifdef ADDER_BIST_STOP_ON_FAIL_EN
    if (exp_err > 0) begin
      exp_lat = 2 * (exp_ff + 1) + 1;
      exp_err = 1;
    end
`endif
  endtask

  // Pulse start from IDLE and count cycles until done (cycle 1 = first busy cycle).
  task automatic run_sweep(input int restart_at, output int lat, output logic busy_c1);
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    busy_c1 = busy;
    lat = 1;
    while (!done && lat < MAX_LAT) begin
      start = (lat == restart_at);
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({A, B, C0} !== 9'h000) begin errors++; $display("FAIL reset_vec got %h want 000", {A, B, C0}); end
    checks++; if ({busy, done, pass} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {busy, done, pass}); end
    checks++; if (err_cnt !== 10'd0) begin errors++; $display("FAIL reset_err_cnt got %0d want 0", err_cnt); end
    checks++; if (first_fail !== 9'h000) begin errors++; $display("FAIL reset_first_fail got %h want 000", first_fail); end
    rst = 1'b0;
  endtask

  task automatic test_correct_adder();
    int lat;
    logic b1;
    fault_mode = 0;
    run_sweep(0, lat, b1);
    checks++; if (b1 !== 1'b1) begin errors++; $display("FAIL good_busy_rise got %b want 1", b1); end
    checks++; if (lat !== FULL_LAT) begin errors++; $display("FAIL good_latency got %0d want %0d", lat, FULL_LAT); end
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL good_pass got %b want 1", pass); end
    checks++; if (err_cnt !== 10'd0) begin errors++; $display("FAIL good_err_cnt got %0d want 0", err_cnt); end
    checks++; if (first_fail !== 9'h000) begin errors++; $display("FAIL good_first_fail got %h want 000", first_fail); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL good_busy_at_done got %b want 0", busy); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL good_done_pulse_width got %b want 0", done); end
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL good_pass_held got %b want 1", pass); end
  endtask

  task automatic test_fault_models();
    int lat, e_err, e_ff, e_lat;
    logic b1;
    for (int m = 1; m <= 5; m++) begin
      fault_mode = (m > 3) ? 3 : m;
      for (int v = 0; v < NVEC; v++)
        flip_tbl[v] = ($urandom_range(0, 23) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      model_expect(e_err, e_ff, e_lat);
      run_sweep(0, lat, b1);
      checks++; if (lat !== e_lat) begin errors++; $display("FAIL fault%0d_latency got %0d want %0d", m, lat, e_lat); end
      checks++; if (err_cnt !== 10'(e_err)) begin errors++; $display("FAIL fault%0d_err_cnt got %0d want %0d", m, err_cnt, e_err); end
      checks++; if (first_fail !== 9'(e_ff)) begin errors++; $display("FAIL fault%0d_first_fail got %h want %h", m, first_fail, 9'(e_ff)); end
      checks++; if (pass !== (e_err == 0)) begin errors++; $display("FAIL fault%0d_pass got %b want %b", m, pass, e_err == 0); end
    end
    fault_mode = 0;
  endtask

  task automatic test_start_ignored();
    int lat;
    logic b1;
    fault_mode = 0;
    run_sweep(50, lat, b1);
    checks++; if (lat !== FULL_LAT) begin errors++; $display("FAIL restart_latency got %0d want %0d", lat, FULL_LAT); end
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL restart_pass got %b want 1", pass); end
  endtask

  task automatic test_reset_mid_sweep();
    int lat, dones;
    logic b1;
    fault_mode = 2;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (299) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if ({A, B, C0, busy, done, pass} !== 12'h000) begin errors++; $display("FAIL midrst_outputs got %h want 000", {A, B, C0, busy, done, pass}); end
    checks++; if ({err_cnt, first_fail} !== 19'h0) begin errors++; $display("FAIL midrst_results got %h want 0", {err_cnt, first_fail}); end
    dones = 0;
    for (int i = 0; i < 1100; i++) begin
      @(posedge clk); #1;
      if (done || busy) dones++;
    end
    checks++; if (dones !== 0) begin errors++; $display("FAIL midrst_idle_activity got %0d want 0", dones); end
    fault_mode = 0;
    run_sweep(0, lat, b1);
    checks++; if (lat !== FULL_LAT || pass !== 1'b1) begin errors++; $display("FAIL midrst_resweep got lat %0d pass %b want %0d 1", lat, pass, FULL_LAT); end
  endtask

  task automatic test_back_to_back();
    int lat, e_err, e_ff, e_lat;
    logic b1;
    fault_mode = 3;
    for (int v = 0; v < NVEC; v++)
      flip_tbl[v] = ($urandom_range(0, 63) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
    flip_tbl[$urandom_range(0, NVEC - 1)] = 5'h10;
    model_expect(e_err, e_ff, e_lat);
    run_sweep(0, lat, b1);
    checks++; if (err_cnt !== 10'(e_err) || first_fail !== 9'(e_ff)) begin errors++; $display("FAIL b2b_first got %0d/%h want %0d/%h", err_cnt, first_fail, e_err, 9'(e_ff)); end
    checks++; if (pass !== 1'b0) begin errors++; $display("FAIL b2b_first_pass got %b want 0", pass); end
    fault_mode = 0;
    run_sweep(0, lat, b1);
    checks++; if (lat !== FULL_LAT) begin errors++; $display("FAIL b2b_second_latency got %0d want %0d", lat, FULL_LAT); end
    checks++; if (err_cnt !== 10'd0 || first_fail !== 9'h000 || pass !== 1'b1) begin errors++; $display("FAIL b2b_second got %0d/%h/%b want 0/000/1", err_cnt, first_fail, pass); end
  endtask

  initial begin
    test_reset();
    test_correct_adder();
    test_fault_models();
    test_start_ignored();
    test_reset_mid_sweep();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
